// File: rtl/edge_detection_pkg.sv
// Shared constants for the edge-detection pipeline: pixel depth, matrix tap
// positions inside the packed 3x3 neighbourhood, gradient width and threshold.
package edge_detection_pkg;

  localparam int SUBPIXEL_DEPTH    = 8;
  localparam int GRADIENT_WIDTH    = SUBPIXEL_DEPTH + 3;
  localparam int THRESHOLD_DEFAULT = 64;

  // Slice index of each tap; slice k occupies bits [k*D +: D]
  localparam int TAP_TL = 7;
  localparam int TAP_T  = 6;
  localparam int TAP_TR = 5;
  localparam int TAP_ML = 4;
  localparam int TAP_MR = 3;
  localparam int TAP_BL = 2;
  localparam int TAP_B  = 1;
  localparam int TAP_BR = 0;

endpackage

// File: rtl/sobel_axis_gradient.sv
// Signed 1-2-1 weighted difference of three positive and three negative taps;
// one instance per gradient axis.
module sobel_axis_gradient
  import edge_detection_pkg::*;
#(
  parameter int P_DEPTH = SUBPIXEL_DEPTH
) (
  input  logic [P_DEPTH-1:0]        pos_outer_a,
  input  logic [P_DEPTH-1:0]        pos_center,
  input  logic [P_DEPTH-1:0]        pos_outer_b,
  input  logic [P_DEPTH-1:0]        neg_outer_a,
  input  logic [P_DEPTH-1:0]        neg_center,
  input  logic [P_DEPTH-1:0]        neg_outer_b,
  output logic signed [P_DEPTH+2:0] gradient
);

  localparam int W = P_DEPTH + 3;

  logic [W-1:0] pos_sum_s;
  logic [W-1:0] neg_sum_s;

  // Each side sums to at most 4*(2^D-1), so D+2 bits; the extra bit carries the sign
  always_comb begin
    pos_sum_s = W'(pos_outer_a) + W'({pos_center, 1'b0}) + W'(pos_outer_b);
    neg_sum_s = W'(neg_outer_a) + W'({neg_center, 1'b0}) + W'(neg_outer_b);
    gradient  = signed'(pos_sum_s - neg_sum_s);
  end

endmodule

// File: rtl/sobel_edge_detector.sv
// Pipelined Sobel magnitude with threshold/saturation and a per-frame edge count.
// Input capture -> S1 gradients -> S2 absolute values -> S3 magnitude/output.
module sobel_edge_detector
  import edge_detection_pkg::*;
#(
  parameter int P_FRAME_COLUMNS  = 640,
  parameter int P_FRAME_ROWS     = 480,
  parameter int P_SUBPIXEL_DEPTH = SUBPIXEL_DEPTH,
  parameter int P_THRESHOLD      = THRESHOLD_DEFAULT,
  localparam int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  localparam int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  localparam int P_EDGE_COUNT_BITS   = $clog2(P_FRAME_COLUMNS * P_FRAME_ROWS + 1)
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_ENABLE,
  input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
  input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
  input  logic [8*P_SUBPIXEL_DEPTH-1:0]  I_PIXEL_MATRIX,
  input  logic                           I_PIXEL_MATRIX_READY,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
  output logic [P_SUBPIXEL_DEPTH-1:0]    O_EDGE_PIXEL,
  output logic                           O_EDGE_VALID,
  output logic [P_EDGE_COUNT_BITS-1:0]   O_EDGE_COUNT,
  output logic                           O_FRAME_DONE
);

  localparam int D  = P_SUBPIXEL_DEPTH;
  localparam int GW = D + 3;
  localparam int AW = D + 2;
  localparam int CB = P_FRAME_COLUMN_BITS;
  localparam int RB = P_FRAME_ROW_BITS;
  localparam int EB = P_EDGE_COUNT_BITS;

  localparam logic [GW-1:0] THRESHOLD_MAG = GW'(P_THRESHOLD);
  localparam logic [GW-1:0] PIXEL_MAX     = GW'((2 ** D) - 1);
  localparam logic [CB-1:0] COLUMN_LAST   = CB'(P_FRAME_COLUMNS - 3);
  localparam logic [RB-1:0] ROW_LAST      = RB'(P_FRAME_ROWS - 3);

  logic [8*D-1:0]        s0_matrix_r;
  logic [CB-1:0]         s0_column_r, s1_column_r, s2_column_r, out_column_r;
  logic [RB-1:0]         s0_row_r, s1_row_r, s2_row_r, out_row_r;
  logic                  s0_valid_r, s1_valid_r, s2_valid_r, s3_valid_r;
  logic signed [GW-1:0]  gx_s, gy_s, s1_gx_r, s1_gy_r;
  logic [AW-1:0]         abs_gx_s, abs_gy_s, s2_abs_gx_r, s2_abs_gy_r;
  logic [GW-1:0]         mag_s;
  logic                  is_edge_s, frame_end_s;
  logic [D-1:0]          pixel_s, edge_pixel_r;
  logic [EB-1:0]         running_count_r, count_next_s, edge_count_r;
  logic                  frame_done_r;

  sobel_axis_gradient #(.P_DEPTH(D)) u_gradient_x (
    .pos_outer_a (s0_matrix_r[TAP_TR*D +: D]),
    .pos_center  (s0_matrix_r[TAP_MR*D +: D]),
    .pos_outer_b (s0_matrix_r[TAP_BR*D +: D]),
    .neg_outer_a (s0_matrix_r[TAP_TL*D +: D]),
    .neg_center  (s0_matrix_r[TAP_ML*D +: D]),
    .neg_outer_b (s0_matrix_r[TAP_BL*D +: D]),
    .gradient    (gx_s)
  );

  sobel_axis_gradient #(.P_DEPTH(D)) u_gradient_y (
    .pos_outer_a (s0_matrix_r[TAP_BL*D +: D]),
    .pos_center  (s0_matrix_r[TAP_B*D +: D]),
    .pos_outer_b (s0_matrix_r[TAP_BR*D +: D]),
    .neg_outer_a (s0_matrix_r[TAP_TL*D +: D]),
    .neg_center  (s0_matrix_r[TAP_T*D +: D]),
    .neg_outer_b (s0_matrix_r[TAP_TR*D +: D]),
    .gradient    (gy_s)
  );

  // Absolute values, magnitude, threshold/saturation, counter and frame-end detect
  always_comb begin
    abs_gx_s    = s1_gx_r[GW-1] ? AW'(-s1_gx_r) : AW'(s1_gx_r);
    abs_gy_s    = s1_gy_r[GW-1] ? AW'(-s1_gy_r) : AW'(s1_gy_r);
    mag_s       = GW'(s2_abs_gx_r) + GW'(s2_abs_gy_r);
    is_edge_s   = (mag_s >= THRESHOLD_MAG);
    frame_end_s = s2_valid_r && (s2_column_r == COLUMN_LAST) && (s2_row_r == ROW_LAST);
    if (!is_edge_s) begin
      pixel_s = '0;
    end else if (mag_s > PIXEL_MAX) begin
      pixel_s = '1;
    end else begin
      pixel_s = mag_s[D-1:0];
    end
    // Saturating count; the frame-end pixel itself is included in the published value
    if (s2_valid_r && is_edge_s && (running_count_r != '1)) begin
      count_next_s = running_count_r + EB'(1);
    end else begin
      count_next_s = running_count_r;
    end
  end

  // Pipeline, counters and frame-end registers; everything freezes while disabled
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      s0_matrix_r     <= '0;
      s0_column_r     <= '0;
      s0_row_r        <= '0;
      s0_valid_r      <= 1'b0;
      s1_gx_r         <= '0;
      s1_gy_r         <= '0;
      s1_column_r     <= '0;
      s1_row_r        <= '0;
      s1_valid_r      <= 1'b0;
      s2_abs_gx_r     <= '0;
      s2_abs_gy_r     <= '0;
      s2_column_r     <= '0;
      s2_row_r        <= '0;
      s2_valid_r      <= 1'b0;
      edge_pixel_r    <= '0;
      out_column_r    <= '0;
      out_row_r       <= '0;
      s3_valid_r      <= 1'b0;
      running_count_r <= '0;
      edge_count_r    <= '0;
      frame_done_r    <= 1'b0;
    end else if (I_ENABLE) begin
      s0_matrix_r  <= I_PIXEL_MATRIX;
      s0_column_r  <= I_PIXEL_COLUMN;
      s0_row_r     <= I_PIXEL_ROW;
      s0_valid_r   <= I_PIXEL_MATRIX_READY;
      s1_gx_r      <= gx_s;
      s1_gy_r      <= gy_s;
      s1_column_r  <= s0_column_r;
      s1_row_r     <= s0_row_r;
      s1_valid_r   <= s0_valid_r;
      s2_abs_gx_r  <= abs_gx_s;
      s2_abs_gy_r  <= abs_gy_s;
      s2_column_r  <= s1_column_r;
      s2_row_r     <= s1_row_r;
      s2_valid_r   <= s1_valid_r;
      edge_pixel_r <= pixel_s;
      out_column_r <= s2_column_r;
      out_row_r    <= s2_row_r;
      s3_valid_r   <= s2_valid_r;
      if (frame_end_s) begin
        edge_count_r    <= count_next_s;
        running_count_r <= '0;
        frame_done_r    <= 1'b1;
      end else begin
        running_count_r <= count_next_s;
        frame_done_r    <= 1'b0;
      end
    end
  end

  // Strobes are qualified by enable so a frozen result is presented exactly once
  assign O_EDGE_VALID   = s3_valid_r & I_ENABLE;
  assign O_FRAME_DONE   = frame_done_r & I_ENABLE;
  assign O_EDGE_PIXEL   = edge_pixel_r;
  assign O_PIXEL_COLUMN = out_column_r;
  assign O_PIXEL_ROW    = out_row_r;
  assign O_EDGE_COUNT   = edge_count_r;

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Self-checking bench for sobel_edge_detector on an 8x6 frame: vector table,
// scoreboard of expected results, latency/stall/bubble/frame/reset sequences.
module tb_sobel_edge_detector;

  localparam int COLS = 8;
  localparam int ROWS = 6;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [2:0]  in_col;
  logic [2:0]  in_row;
  logic [63:0] in_matrix;
  logic        in_ready;
  logic [2:0]  out_col;
  logic [2:0]  out_row;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic [5:0]  out_count;
  logic        out_done;

  sobel_edge_detector #(
    .P_FRAME_COLUMNS (COLS),
    .P_FRAME_ROWS    (ROWS),
    .P_SUBPIXEL_DEPTH(8),
    .P_THRESHOLD     (64)
  ) dut (
    .I_CLK               (clk),
    .I_RESET             (rst_n),
    .I_ENABLE            (enable),
    .I_PIXEL_COLUMN      (in_col),
    .I_PIXEL_ROW         (in_row),
    .I_PIXEL_MATRIX      (in_matrix),
    .I_PIXEL_MATRIX_READY(in_ready),
    .O_PIXEL_COLUMN      (out_col),
    .O_PIXEL_ROW         (out_row),
    .O_EDGE_PIXEL        (out_pixel),
    .O_EDGE_VALID        (out_valid),
    .O_EDGE_COUNT        (out_count),
    .O_FRAME_DONE        (out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] M_VERT = 64'h0000FF00FF0000FF;
  localparam logic [63:0] M_UNIF = 64'h6464646464646464;
  localparam logic [63:0] M_TL50 = 64'h3200000000000000;

  typedef struct {
    logic [63:0] m;
    logic [2:0]  col;
    logic [2:0]  row;
    logic [7:0]  pix;
  } vec_t;

  typedef struct {
    int pix;
    int col;
    int row;
    bit done;
    int count;
  } exp_t;

  vec_t  tbl [11];
  exp_t  sb [$];
  int    checks = 0;
  int    passes = 0;
  int    model_count = 0;
  int    done_seen = 0;
  int    cyc = 0;
  bit    vlog [0:4095];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int ref_mag(input logic [63:0] m);
    int tl = int'(m[63:56]); int t  = int'(m[55:48]); int tr = int'(m[47:40]);
    int ml = int'(m[39:32]); int mr = int'(m[31:24]);
    int bl = int'(m[23:16]); int b  = int'(m[15:8]);  int br = int'(m[7:0]);
    int gx = (tr + 2*mr + br) - (tl + 2*ml + bl);
    int gy = (bl + 2*b + br) - (tl + 2*t + tr);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int ref_pix(input int mag);
    if (mag < 64) return 0;
    else if (mag > 255) return 255;
    else return mag;
  endfunction

  // One clock: log the presented valid mid-cycle, then move to just after the next edge
  task automatic tick();
    @(negedge clk);
    vlog[cyc] = out_valid;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] m, input int col, input int row,
                       input bit ready, input int pix);
    exp_t e;
    in_matrix = m;
    in_col    = 3'(col);
    in_row    = 3'(row);
    in_ready  = ready;
    if (ready && enable) begin
      if (ref_mag(m) >= 64 && model_count < 63) model_count++;
      e.pix   = pix;
      e.col   = col;
      e.row   = row;
      e.done  = (col == COLS - 3) && (row == ROWS - 3);
      e.count = model_count;
      if (e.done) model_count = 0;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(64'h0, 0, 0, 1'b0, 0);
  endtask

  task automatic run_frame(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      bit edge_px = (kind == 0) ? ((i % 5 == 0) || (i % 5 == 2)) : (i % 3 == 0);
      logic [63:0] m = edge_px ? M_VERT : M_UNIF;
      drive(m, i % 6, i / 6, 1'b1, ref_pix(ref_mag(m)));
    end
  endtask

  // Asserted mid-cycle, between clock edges, so its effect is asynchronous
  task automatic reset_midcycle(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_pixel"}, out_pixel, 0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_done"},  out_done, 0);
    check({tag, "_coords"}, {out_col, out_row}, 0);
    sb.delete();
    model_count = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every presented result must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("edge_pixel", out_pixel, e.pix);
          check("coords_col_row", {out_col, out_row}, (e.col << 3) | e.row);
          check("frame_done", out_done, e.done);
          if (e.done) begin
            check("frame_edge_count", out_count, e.count);
            done_seen++;
          end
        end
      end else begin
        check("done_without_valid", out_done, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tbl[0]  = '{m: M_VERT,             col: 3'd0, row: 3'd2, pix: 8'd255};
    tbl[1]  = '{m: M_UNIF,             col: 3'd1, row: 3'd2, pix: 8'd0};
    tbl[2]  = '{m: 64'h0000140000000000, col: 3'd2, row: 3'd2, pix: 8'd0};
    tbl[3]  = '{m: 64'h0000140014000014, col: 3'd3, row: 3'd2, pix: 8'd80};
    tbl[4]  = '{m: 64'h0000000000FFFFFF, col: 3'd4, row: 3'd2, pix: 8'd255};
    tbl[5]  = '{m: 64'h000000001F000000, col: 3'd5, row: 3'd2, pix: 8'd0};
    tbl[6]  = '{m: 64'h0000000020000000, col: 3'd6, row: 3'd2, pix: 8'd64};
    tbl[7]  = '{m: 64'h0000000080000000, col: 3'd7, row: 3'd2, pix: 8'd255};
    tbl[8]  = '{m: 64'h000000007F000000, col: 3'd0, row: 3'd4, pix: 8'd254};
    tbl[9]  = '{m: 64'hFF0000FF00FF0000, col: 3'd1, row: 3'd4, pix: 8'd255};
    tbl[10] = '{m: M_TL50,             col: 3'd2, row: 3'd4, pix: 8'd100};

    rst_n = 1'b0; enable = 1'b1; in_ready = 1'b0; in_matrix = '0; in_col = '0; in_row = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_pixel", out_pixel, 0);
    check("reset_count", out_count, 0);
    check("reset_done", out_done, 0);
    check("reset_coords", {out_col, out_row}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) drive(tbl[i].m, tbl[i].col, tbl[i].row, 1'b1, tbl[i].pix);
    idle(6);
    check("table_drained", sb.size(), 0);

    c0 = cyc;
    drive(M_VERT, 2, 1, 1'b1, 255);
    idle(5);
    for (int k = 1; k <= 5; k++) check($sformatf("latency_cycle%0d", k), vlog[c0 + k], (k == 4));

    reset_midcycle("reset_clean");
    done_seen = 0;
    run_frame(0, 24);
    idle(6);
    check("frame1_count", out_count, 10);
    check("frame1_done_pulses", done_seen, 1);
    run_frame(0, 24);
    idle(6);
    check("frame2_count", out_count, 10);
    check("frame2_done_pulses", done_seen, 2);

    drive(M_VERT, 0, 0, 1'b1, 255);
    drive(M_UNIF, 1, 0, 1'b1, 0);
    drive(M_VERT, 2, 0, 1'b1, 255);
    drive(M_TL50, 3, 0, 1'b1, 100);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(M_VERT, 4, 0, 1'b1, 255);
      check("stall_valid_low", vlog[cyc - 1], 0);
    end
    enable = 1'b1;
    idle(6);
    check("stall_drained", sb.size(), 0);
    drive(M_VERT, 5, 3, 1'b1, 255);
    idle(6);
    check("stall_frame_count", out_count, 4);
    check("stall_done_pulses", done_seen, 3);

    c0 = cyc;
    for (int i = 0; i < 8; i++) drive(M_UNIF, i, 1, (i % 2 == 0), 0);
    idle(6);
    for (int i = 0; i < 8; i++) check($sformatf("bubble_valid%0d", i), vlog[c0 + 4 + i], (i % 2 == 0));

    run_frame(0, 10);
    reset_midcycle("reset_midframe");
    run_frame(1, 24);
    idle(6);
    check("post_reset_frame_count", out_count, 8);
    check("post_reset_done_pulses", done_seen, 4);
    check("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
